// File: rtl/dcache_ctrl_if.sv
// Processor-side and backing-memory-side signal bundle for dcache_ctrl.
interface dcache_ctrl_if;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        rd;
  logic        wr;
  logic [15:0] data_out;
  logic        done;
  logic        stall;
  logic        cache_hit;
  logic        err;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic [15:0] req_count;
  logic [15:0] hit_count;

  modport slave (
    input  addr, data_in, rd, wr, mem_rdata, mem_ack,
    output data_out, done, stall, cache_hit, err,
           mem_addr, mem_wdata, mem_rd, mem_wr, req_count, hit_count
  );

  modport master (
    output addr, data_in, rd, wr, mem_rdata, mem_ack,
    input  data_out, done, stall, cache_hit, err,
           mem_addr, mem_wdata, mem_rd, mem_wr, req_count, hit_count
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache with miss FSM.
// Lines hold 4x16-bit words; backing memory moves one word per mem_ack.
// Optional access statistics are built only when DCACHE_STATS_EN is defined.
module dcache_ctrl #(
  parameter int unsigned IDX_BITS = 3
) (
  input logic         clk,
  input logic         rst,
  dcache_ctrl_if.slave bus
);
  localparam int unsigned TAG_BITS  = 16 - 3 - IDX_BITS;
  localparam int unsigned NUM_LINES = 1 << IDX_BITS;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WB   = 2'd1;
  localparam logic [1:0] FILL = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]           stateQ, stateD;
  logic [1:0]           cntQ;
  logic [NUM_LINES-1:0] validQ, dirtyQ;
  logic [TAG_BITS-1:0]  tagQ  [NUM_LINES];
  logic [15:0]          dataQ [NUM_LINES][4];

  logic [TAG_BITS-1:0]  reqTagQ;
  logic [IDX_BITS-1:0]  reqIdxQ;
  logic [1:0]           reqOffQ;
  logic                 reqRdQ;
  logic [15:0]          reqDataQ;

  logic [TAG_BITS-1:0]  inTag;
  logic [IDX_BITS-1:0]  inIdx;
  logic [1:0]           inOff;
  logic                 anyReq, illegalReq, lineHit, victimDirty;
  logic                 idleHit, idleMiss, ackLast;

  logic                 doneC, stallC, hitC, errC, memRdC, memWrC;
  logic [15:0]          dataOutC, memAddrC, memWdataC;

  assign inTag       = bus.addr[15:3+IDX_BITS];
  assign inIdx       = bus.addr[2+IDX_BITS:3];
  assign inOff       = bus.addr[2:1];
  assign anyReq      = bus.rd | bus.wr;
  assign illegalReq  = anyReq & ((bus.rd & bus.wr) | bus.addr[0]);
  assign lineHit     = validQ[inIdx] && (tagQ[inIdx] == inTag);
  assign victimDirty = validQ[inIdx] && dirtyQ[inIdx];
  assign idleHit     = (stateQ == IDLE) && anyReq && !illegalReq && lineHit;
  assign idleMiss    = (stateQ == IDLE) && anyReq && !illegalReq && !lineHit;
  assign ackLast     = bus.mem_ack && (cntQ == 2'd3);

  // State register
  always_ff @(posedge clk) begin
    if (rst) stateQ <= IDLE;
    else     stateQ <= stateD;
  end

  // Next-state selection
  always_comb begin
    stateD = stateQ;
    case (stateQ)
      IDLE:    if (idleMiss) stateD = victimDirty ? WB : FILL;
      WB:      if (ackLast)  stateD = FILL;
      FILL:    if (ackLast)  stateD = RESP;
      RESP:    stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  // Per-state outputs; hits and illegal requests answer in the same cycle
  always_comb begin
    doneC     = 1'b0;
    stallC    = 1'b0;
    hitC      = 1'b0;
    errC      = 1'b0;
    memRdC    = 1'b0;
    memWrC    = 1'b0;
    dataOutC  = 16'h0000;
    memAddrC  = 16'h0000;
    memWdataC = 16'h0000;
    case (stateQ)
      IDLE: begin
        if (illegalReq) begin
          doneC = 1'b1;
          errC  = 1'b1;
        end else if (idleHit) begin
          doneC = 1'b1;
          hitC  = 1'b1;
          if (bus.rd) dataOutC = dataQ[inIdx][inOff];
        end else if (idleMiss) begin
          stallC = 1'b1;
        end
      end
      WB: begin
        stallC    = 1'b1;
        memWrC    = 1'b1;
        memAddrC  = {tagQ[reqIdxQ], reqIdxQ, cntQ, 1'b0};
        memWdataC = dataQ[reqIdxQ][cntQ];
      end
      FILL: begin
        stallC   = 1'b1;
        memRdC   = 1'b1;
        memAddrC = {reqTagQ, reqIdxQ, cntQ, 1'b0};
      end
      RESP: begin
        doneC = 1'b1;
        if (reqRdQ) dataOutC = dataQ[reqIdxQ][reqOffQ];
      end
      default: ;
    endcase
  end

  // Miss bookkeeping: latched request and burst word counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cntQ     <= 2'd0;
      reqTagQ  <= '0;
      reqIdxQ  <= '0;
      reqOffQ  <= 2'd0;
      reqRdQ   <= 1'b0;
      reqDataQ <= 16'h0000;
    end else if (idleMiss) begin
      cntQ     <= 2'd0;
      reqTagQ  <= inTag;
      reqIdxQ  <= inIdx;
      reqOffQ  <= inOff;
      reqRdQ   <= bus.rd;
      reqDataQ <= bus.data_in;
    end else if ((stateQ == WB || stateQ == FILL) && bus.mem_ack) begin
      cntQ <= cntQ + 2'd1;
    end
  end

  // Valid/dirty state; a line becomes valid only after its last fill word
  always_ff @(posedge clk) begin
    if (rst) begin
      validQ <= '0;
      dirtyQ <= '0;
    end else begin
      if (idleHit && bus.wr) dirtyQ[inIdx] <= 1'b1;
      if (stateQ == FILL && ackLast) begin
        validQ[reqIdxQ] <= 1'b1;
        dirtyQ[reqIdxQ] <= 1'b0;
      end
      if (stateQ == RESP && !reqRdQ) dirtyQ[reqIdxQ] <= 1'b1;
    end
  end

  // Tag and data arrays (contents undefined after reset)
  always_ff @(posedge clk) begin
    if (idleHit && bus.wr)             dataQ[inIdx][inOff]     <= bus.data_in;
    if (stateQ == FILL && bus.mem_ack) dataQ[reqIdxQ][cntQ]    <= bus.mem_rdata;
    if (stateQ == RESP && !reqRdQ)     dataQ[reqIdxQ][reqOffQ] <= reqDataQ;
    if (stateQ == FILL && ackLast)     tagQ[reqIdxQ]           <= reqTagQ;
  end

`ifdef DCACHE_STATS_EN
  logic [15:0] reqCntQ, hitCntQ;

  // Saturating counts of legal completions and of hits
  always_ff @(posedge clk) begin
    if (rst) begin
      reqCntQ <= 16'h0000;
      hitCntQ <= 16'h0000;
    end else begin
      if (doneC && !errC && reqCntQ != 16'hFFFF) reqCntQ <= reqCntQ + 16'd1;
      if (doneC && hitC && hitCntQ != 16'hFFFF)  hitCntQ <= hitCntQ + 16'd1;
    end
  end

  assign bus.req_count = reqCntQ;
  assign bus.hit_count = hitCntQ;
`else
  assign bus.req_count = 16'h0000;
  assign bus.hit_count = 16'h0000;
`endif

  assign bus.done      = doneC;
  assign bus.stall     = stallC;
  assign bus.cache_hit = hitC;
  assign bus.err       = errC;
  assign bus.data_out  = dataOutC;
  assign bus.mem_rd    = memRdC;
  assign bus.mem_wr    = memWrC;
  assign bus.mem_addr  = memAddrC;
  assign bus.mem_wdata = memWdataC;
endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: architectural memory model plus resident-line map,
// a backing-memory responder with transaction log, and a per-cycle monitor.
`timescale 1ns/1ps
module tb_dcache_ctrl;
  localparam int MEMW = 1024;
`ifdef DCACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct packed {
    logic        isWr;
    logic [15:0] a;
    logic [15:0] d;
  } txn_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dcache_ctrl_if bus();
  dcache_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  int nCmp = 0;
  int nBad = 0;

  logic [15:0] mem  [MEMW];
  logic [15:0] arch [MEMW];
  bit          mValid [8];
  bit          mDirty [8];
  int          mTag   [8];
  int          modelReq, modelHit;
  txn_t        logQ[$];
  txn_t        expQ[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Backing memory: one ack per request word, one idle cycle between words
  always @(posedge clk) begin
    txn_t t;
    if (rst) bus.mem_ack <= 1'b0;
    else if (bus.mem_ack) bus.mem_ack <= 1'b0;
    else if (bus.mem_rd || bus.mem_wr) begin
      bus.mem_ack <= 1'b1;
      t.isWr = bus.mem_wr;
      t.a    = bus.mem_addr;
      if (bus.mem_wr) begin
        t.d = bus.mem_wdata;
        mem[bus.mem_addr[10:1]] = bus.mem_wdata;
      end else begin
        t.d = mem[bus.mem_addr[10:1]];
        bus.mem_rdata <= mem[bus.mem_addr[10:1]];
      end
      logQ.push_back(t);
    end
  end

  // Per-cycle protocol monitor, sampled after each edge has settled
  logic        pValid = 1'b0;
  logic        pReq, pWr, pAck;
  logic [15:0] pAddr, pData;
  always @(posedge clk) begin
    #2;
    if (rst) pValid = 1'b0;
    else begin
      check("mon_rd_wr_excl", 32'(bus.mem_rd & bus.mem_wr), 32'd0);
      if (!bus.stall) check("mon_quiet_mem", 32'({bus.mem_rd, bus.mem_wr}), 32'd0);
      if (pValid && pReq && !pAck) begin
        check("mon_hold_addr", 32'(bus.mem_addr), 32'(pAddr));
        check("mon_hold_kind", 32'(bus.mem_wr), 32'(pWr));
        if (pWr) check("mon_hold_wdata", 32'(bus.mem_wdata), 32'(pData));
      end
      pValid = 1'b1;
      pReq   = bus.mem_rd | bus.mem_wr;
      pWr    = bus.mem_wr;
      pAck   = bus.mem_ack;
      pAddr  = bus.mem_addr;
      pData  = bus.mem_wdata;
    end
  end

  // Reset loses un-written-back stores: the visible image becomes backing memory
  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      mValid[i] = 1'b0;
      mDirty[i] = 1'b0;
      mTag[i]   = 0;
    end
    for (int i = 0; i < MEMW; i++) arch[i] = mem[i];
    modelReq = 0;
    modelHit = 0;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    bus.rd = 1'b0;
    bus.wr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // One access, called at a negedge; returns data_out at done and log start
  task automatic access(input logic r, input logic w, input logic [15:0] a,
                        input logic [15:0] d, input string nm,
                        output logic [15:0] got, output int first);
    bit ill, hit, wbk, seenDone;
    int idx, tg, wd, base, start, nExp;
    txn_t e;
    logic [15:0] expData;
    ill = (r && w) || ((r || w) && a[0]);
    idx = int'(a[5:3]);
    tg  = int'(a[15:6]);
    wd  = int'(a[10:1]);
    hit = !ill && mValid[idx] && (mTag[idx] == tg);
    wbk = !ill && !hit && mValid[idx] && mDirty[idx];
    expQ.delete();
    if (wbk) begin
      base = (mTag[idx] << 6) | (idx << 3);
      for (int k = 0; k < 4; k++) begin
        e.isWr = 1'b1; e.a = 16'(base + 2*k); e.d = arch[(base >> 1) + k];
        expQ.push_back(e);
      end
    end
    if (!ill && !hit) begin
      base = (tg << 6) | (idx << 3);
      for (int k = 0; k < 4; k++) begin
        e.isWr = 1'b0; e.a = 16'(base + 2*k); e.d = arch[(base >> 1) + k];
        expQ.push_back(e);
      end
    end
    expData = arch[wd];
    start = logQ.size();
    first = start;
    bus.rd = r; bus.wr = w; bus.addr = a; bus.data_in = d;
    seenDone = 1'b0;
    #1;
    check({nm, "_done_cyc0"}, 32'(bus.done), 32'(ill || hit));
    for (int cyc = 0; cyc < 100 && !seenDone; cyc++) begin
      if (cyc != 0) #1;
      if (bus.done) begin
        seenDone = 1'b1;
        check({nm, "_stall_at_done"}, 32'(bus.stall), 32'd0);
      end else begin
        check({nm, "_stall"}, 32'(bus.stall), 32'd1);
        @(negedge clk);
      end
    end
    check({nm, "_timeout"}, 32'(seenDone), 32'd1);
    check({nm, "_err"}, 32'(bus.err), 32'(ill));
    check({nm, "_hit"}, 32'(bus.cache_hit), 32'(hit));
    if (r && !ill) check({nm, "_data"}, 32'(bus.data_out), 32'(expData));
    got = bus.data_out;
    if (!ill) begin
      modelReq++;
      if (hit) modelHit++;
      else begin
        mValid[idx] = 1'b1; mTag[idx] = tg; mDirty[idx] = 1'b0;
      end
      if (w) begin
        arch[wd] = d; mDirty[idx] = 1'b1;
      end
    end
    @(negedge clk);
    bus.rd = 1'b0; bus.wr = 1'b0;
    nExp = expQ.size();
    check({nm, "_ntxn"}, 32'(logQ.size() - start), 32'(nExp));
    for (int k = 0; k < nExp && start + k < logQ.size(); k++) begin
      check({nm, "_txn_kind"}, 32'(logQ[start+k].isWr), 32'(expQ[k].isWr));
      check({nm, "_txn_addr"}, 32'(logQ[start+k].a), 32'(expQ[k].a));
      check({nm, "_txn_data"}, 32'(logQ[start+k].d), 32'(expQ[k].d));
    end
    check({nm, "_req_count"}, 32'(bus.req_count), STATS ? 32'(modelReq) : 32'd0);
    check({nm, "_hit_count"}, 32'(bus.hit_count), STATS ? 32'(modelHit) : 32'd0);
  endtask

  function automatic int log_at(input int i, input int field);
    if (i >= logQ.size()) return -1;
    case (field)
      0:       return int'(logQ[i].isWr);
      1:       return int'(logQ[i].a);
      default: return int'(logQ[i].d);
    endcase
  endfunction

  initial begin
    logic [15:0] got;
    int f, nw, start;
    rst = 1'b1;
    bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = 16'h0000; bus.data_in = 16'h0000;
    for (int i = 0; i < MEMW; i++) mem[i] = 16'hA000 + 16'(i);
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_done",      32'(bus.done),      32'd0);
    check("rst_stall",     32'(bus.stall),     32'd0);
    check("rst_err",       32'(bus.err),       32'd0);
    check("rst_hit",       32'(bus.cache_hit), 32'd0);
    check("rst_mem_rd",    32'(bus.mem_rd),    32'd0);
    check("rst_mem_wr",    32'(bus.mem_wr),    32'd0);
    check("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    check("rst_data_out",  32'(bus.data_out),  32'd0);
    check("rst_req_count", 32'(bus.req_count), 32'd0);
    check("rst_hit_count", 32'(bus.hit_count), 32'd0);
    @(negedge clk);

    // Cold load, then same-cycle hit
    access(1'b1, 1'b0, 16'h0012, 16'h0000, "cold_ld", got, f);
    check("cold_ld_lit_data",  32'(got), 32'h0000A009);
    check("cold_ld_lit_addr0", 32'(log_at(f, 1)),   32'h0010);
    check("cold_ld_lit_addr3", 32'(log_at(f+3, 1)), 32'h0016);
    access(1'b1, 1'b0, 16'h0012, 16'h0000, "rehit_ld", got, f);
    check("rehit_ld_lit_data", 32'(got), 32'h0000A009);

    // Store hit then dirty eviction by same-index line
    access(1'b0, 1'b1, 16'h0010, 16'hBEEF, "st_hit", got, f);
    access(1'b1, 1'b0, 16'h0050, 16'h0000, "evict_dirty", got, f);
    check("evict_lit_wb_kind",  32'(log_at(f, 0)),   32'd1);
    check("evict_lit_wb_addr",  32'(log_at(f, 1)),   32'h0010);
    check("evict_lit_wb_data",  32'(log_at(f, 2)),   32'hBEEF);
    check("evict_lit_fill0",    32'(log_at(f+4, 1)), 32'h0050);
    check("evict_lit_data",     32'(got), 32'h0000A028);
    access(1'b1, 1'b0, 16'h0010, 16'h0000, "refetch", got, f);
    check("refetch_lit_data", 32'(got), 32'h0000BEEF);

    // Clean eviction: no write-back traffic
    access(1'b1, 1'b0, 16'h0000, 16'h0000, "clean_a", got, f);
    access(1'b1, 1'b0, 16'h0040, 16'h0000, "clean_b", got, f);
    nw = 0;
    for (int i = f; i < logQ.size(); i++) if (logQ[i].isWr) nw++;
    check("clean_lit_no_wb", 32'(nw), 32'd0);

    // Illegal requests leave the cache untouched
    access(1'b1, 1'b1, 16'h0040, 16'h0000, "ill_rdwr", got, f);
    access(1'b1, 1'b0, 16'h0003, 16'h0000, "ill_odd_ld", got, f);
    access(1'b0, 1'b1, 16'h0041, 16'h5555, "ill_odd_st", got, f);
    access(1'b1, 1'b0, 16'h0040, 16'h0000, "post_ill_hit", got, f);

    // Store miss allocates, then write-back carries the stored word
    access(1'b0, 1'b1, 16'h0106, 16'h1234, "st_miss", got, f);
    access(1'b1, 1'b0, 16'h0106, 16'h0000, "st_miss_ld", got, f);
    check("st_miss_lit_data", 32'(got), 32'h00001234);
    access(1'b1, 1'b0, 16'h0006, 16'h0000, "st_miss_evict", got, f);
    check("st_miss_lit_wb_addr", 32'(log_at(f+3, 1)), 32'h0106);
    check("st_miss_lit_wb_data", 32'(log_at(f+3, 2)), 32'h1234);

    // Statistics: one miss then three hits
    do_reset();
    access(1'b1, 1'b0, 16'h0020, 16'h0000, "stat_miss", got, f);
    access(1'b1, 1'b0, 16'h0020, 16'h0000, "stat_h1", got, f);
    access(1'b1, 1'b0, 16'h0022, 16'h0000, "stat_h2", got, f);
    access(1'b0, 1'b1, 16'h0024, 16'h7777, "stat_h3", got, f);
    check("stat_lit_req", 32'(bus.req_count), STATS ? 32'd4 : 32'd0);
    check("stat_lit_hit", 32'(bus.hit_count), STATS ? 32'd3 : 32'd0);

    // Reset in the middle of a fill
    do_reset();
    bus.rd = 1'b1; bus.addr = 16'h0100;
    start = logQ.size();
    for (int c = 0; c < 50 && logQ.size() < start + 2; c++) @(negedge clk);
    check("midfill_acks", 32'(logQ.size() - start), 32'd2);
    rst = 1'b1; bus.rd = 1'b0;
    @(negedge clk);
    check("midfill_mem_rd", 32'(bus.mem_rd), 32'd0);
    check("midfill_stall",  32'(bus.stall),  32'd0);
    rst = 1'b0;
    model_reset();
    access(1'b1, 1'b0, 16'h0100, 16'h0000, "midfill_refill", got, f);
    check("midfill_lit_ntxn",  32'(logQ.size() - f), 32'd4);
    check("midfill_lit_addr0", 32'(log_at(f, 1)),    32'h0100);
    check("midfill_lit_data",  32'(got), 32'h0000A080);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
